// File: rtl/wb_load_store_master.sv
// wb_load_store_master: single-transaction Wishbone classic master for CPU loads/stores.
// Ports:
//   wb_clk_i, wb_rst_n_i            clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o         request handshake; ready only in IDLE
//   req_we_i, req_size_i,           store/load, 00 byte 01 half 10 word 11 illegal,
//   req_signed_i, req_adr_i,        sign-extend loads, byte address,
//   req_dat_i                       right-aligned store data
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_dat_o, rsp_status_o         extended load data; 00 ok 01 err 10 misaligned 11 timeout
//   wb_adr_o, wb_dat_o, wb_sel_o,   word-aligned address, lane-replicated store data, lane enables
//   wb_we_o, wb_cyc_o, wb_stb_o     write enable, cycle/strobe (always equal)
//   wb_dat_i, wb_ack_i, wb_err_i    slave read data and termination
module wb_load_store_master #(
    parameter bit          BIG_ENDIAN     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d, off_q, off_d, status_q, status_d;
    logic        sgn_q, sgn_d, we_q, we_d, cyc_q, cyc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  off, rsh;
    logic        misaligned;
    logic [3:0]  sel;
    logic [31:0] wdat, lane, ext;
    assign off        = req_adr_i[1:0];
    assign misaligned = (req_size_i == 2'd3) || (req_size_i == 2'd1 && off[0]) ||
                        (req_size_i == 2'd2 && off != 2'd0);
    assign sel  = BIG_ENDIAN ?
                  (req_size_i == 2'd0 ? 4'b1000 >> off : req_size_i == 2'd1 ? 4'b1100 >> off : 4'b1111) :
                  (req_size_i == 2'd0 ? 4'b0001 << off : req_size_i == 2'd1 ? 4'b0011 << off : 4'b1111);
    assign wdat = req_size_i == 2'd0 ? {4{req_dat_i[7:0]}} :
                  req_size_i == 2'd1 ? {2{req_dat_i[15:0]}} : req_dat_i;
    // Byte-lane distance of the addressed item from bit 0 of the bus word.
    assign rsh  = BIG_ENDIAN ?
                  (size_q == 2'd0 ? 2'd3 - off_q : size_q == 2'd1 ? 2'd2 - off_q : 2'd0) :
                  (size_q == 2'd2 ? 2'd0 : off_q);
    assign lane = wb_dat_i >> {rsh, 3'b000};
    assign ext  = size_q == 2'd0 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'd1 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : lane;
    assign req_ready_o  = state_q == IDLE;
    assign rsp_valid_o  = state_q == RESP;
    assign rsp_dat_o    = rdat_q;
    assign rsp_status_o = status_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        off_d    = off_q;
        sgn_d    = sgn_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        rdat_d   = rdat_q;
        status_d = status_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                size_d = req_size_i;
                off_d  = off;
                sgn_d  = req_signed_i;
                rdat_d = '0;
                if (misaligned) begin
                    state_d  = RESP;
                    status_d = 2'b10;
                end else begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = req_we_i;
                    sel_d   = sel;
                    adr_d   = {req_adr_i[31:2], 2'b00};
                    dat_d   = req_we_i ? wdat : '0;
                    cnt_d   = '0;
                end
            end
            BUS: begin
                // Any termination leaves BUS and drops the strobe on this same edge.
                if (wb_err_i || wb_ack_i ||
                    (TIMEOUT_CYCLES != 0 && cnt_q == 16'(TIMEOUT_CYCLES - 1))) begin
                    state_d  = RESP;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = '0;
                    status_d = wb_err_i ? 2'b01 : wb_ack_i ? 2'b00 : 2'b11;
                    rdat_d   = (!wb_err_i && wb_ack_i && !we_q) ? ext : '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            size_q   <= '0;
            off_q    <= '0;
            sgn_q    <= 1'b0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            rdat_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            off_q    <= off_d;
            sgn_q    <= sgn_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            rdat_q   <= rdat_d;
            status_q <= status_d;
        end
    end
endmodule
